pll_status_rdbk: RTL and testbench
==================================

PLL_STATUS_RDBK -- requirements
Module: pll_status_rdbk

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for the asynchronous PLL lock input.
REQ-002 Parameter LOCK_FILTER, default 4: consecutive synchronized-high cycles required to declare lock.
REQ-003 Parameter TIMEOUT, default 16'd4000: WAIT_LOCK cycle count at which the lock timeout is flagged.
REQ-004 clk_i  input  1  single block clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 pllen_i  input  1  PLL enable, as driven from the PLL register map.
REQ-007 pll_lock_i  input  1  raw PLL lock, asynchronous to clk_i.
REQ-008 en_read  input  1  read strobe, one cycle per access.
REQ-009 rd_addr  input  2  read word select, sampled with en_read.
REQ-010 en_write  input  1  write strobe, used only for sticky clear.
REQ-011 wr_clr  input  2  clear mask on en_write: bit0 = lost_sticky, bit1 = timeout_sticky.
REQ-012 rd_data  output  32  readback word.
REQ-013 rd_valid  output  1  one-cycle qualifier for rd_data.
REQ-014 locked_o  output  1  filtered lock status (high only in LOCKED).
REQ-015 lock_lost_irq  output  1  one-cycle pulse on every LOCKED->LOST transition.

Function
REQ-016 pll_lock_i passes through a SYNC_STAGES flop chain; only the final stage (lock_s) is used.
REQ-017 FSM states: IDLE=2'd0, WAIT_LOCK=2'd1, LOCKED=2'd2, LOST=2'd3.
REQ-018 IDLE -> WAIT_LOCK when pllen_i=1; lock-time counter cleared to 0 and filter counter cleared to 0 on entry.
REQ-019 WAIT_LOCK: lock-time counter increments each cycle, saturating at 16'hFFFF.
REQ-020 WAIT_LOCK: filter counter increments while lock_s=1 and clears when lock_s=0; when it reaches LOCK_FILTER-1 with lock_s=1 -> LOCKED.
REQ-021 On WAIT_LOCK->LOCKED the current lock-time counter value (including the final cycle) is captured into lock_time; it is held until the next capture or reset.
REQ-022 WAIT_LOCK: when the lock-time counter equals TIMEOUT, timeout_sticky is set; the FSM stays in WAIT_LOCK.
REQ-023 LOCKED -> LOST on the first cycle with lock_s=0; no deassert filtering.
REQ-024 On LOCKED->LOST: lock_lost_irq pulses for one cycle, lost_sticky is set, and loss_cnt (8 bits) increments, saturating at 8'hFF.
REQ-025 LOST -> WAIT_LOCK unconditionally on the next cycle, with counters cleared as in REQ-018.
REQ-026 pllen_i=0 in any state -> IDLE on the next cycle; this has priority over all other transitions, and no loss event is recorded.
REQ-027 Read latency is 1 cycle: en_read in cycle N gives rd_valid=1 in N+1, with data sampled from the registers in cycle N.
REQ-028 rd_data is 0 whenever rd_valid=0.
REQ-029 Back-to-back reads are supported, one per cycle, with no stall.
REQ-030 Word map:
- addr0 = {26'b0, timeout_sticky, lost_sticky, locked_o, lock_s, state[1:0]}
- addr1 = {16'b0, lock_time}
- addr2 = {24'b0, loss_cnt}
- addr3 = 32'h504C_4C31
REQ-031 en_write clears the sticky bits selected by wr_clr; if a set and a clear hit the same bit in the same cycle, the set wins.
REQ-032 A read and a state update in the same cycle return the pre-update value.

Reset
REQ-033 With rst_i high at a clock edge:
- state=IDLE
- sync chain, filter counter, lock-time counter, lock_time, loss_cnt, both stickies = 0
- rd_valid=0, rd_data=0, locked_o=0, lock_lost_irq=0
REQ-034 Reset asserted mid-operation, including mid-read, discards the pending rd_valid in the following cycle.

Verification
REQ-035 pllen_i=1; pll_lock_i rises 100 cycles later and stays high -> locked_o=1 after SYNC_STAGES+LOCK_FILTER further cycles; read addr1 returns 105 (+/-1 per the sync alignment, checked exactly against the model).
REQ-036 Locked, then pll_lock_i low for 3 cycles -> exactly one lock_lost_irq pulse; addr2=1; addr0 bit4=1; FSM passes LOST then WAIT_LOCK.
REQ-037 pllen_i=1 with pll_lock_i stuck 0 -> addr0 bit5 set exactly when the lock-time counter reaches 4000; the FSM remains in WAIT_LOCK.
REQ-038 Lock glitch high for 3 cycles (less than LOCK_FILTER) in WAIT_LOCK -> locked_o stays 0; the filter restarts.
REQ-039 en_write with wr_clr=2'b01 in the same cycle as a new loss event -> lost_sticky remains 1; a later clear gives addr0 bit4=0.
REQ-040 Continuous reads of addr0..3, then rst_i in mid-stream -> rd_valid=0 in the next cycle; addr3 always returns 32'h504C_4C31; 300 loss events give addr2=8'hFF.

Source files
------------

// File: rtl/pll_status_rdbk.sv
// PLL lock supervisor: synchronises the raw lock, filters it through a small FSM,
// records lock time, loss count and sticky flags, and serves them over a 1-cycle read port.
module pll_status_rdbk #(
  parameter int          SYNC_STAGES = 2,
  parameter int          LOCK_FILTER = 4,
  parameter logic [15:0] TIMEOUT     = 16'd4000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pllen_i,
  input  logic        pll_lock_i,
  input  logic        en_read,
  input  logic [1:0]  rd_addr,
  input  logic        en_write,
  input  logic [1:0]  wr_clr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        locked_o,
  output logic        lock_lost_irq
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER - 1);
  localparam logic [31:0] ID_WORD   = 32'h504C_4C31;

  state_t                 state_r;
  state_t                 next_state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  logic [15:0]            filt_cnt_r;
  logic [15:0]            lt_cnt_r;
  logic [15:0]            lt_next_s;
  logic [15:0]            lock_time_r;
  logic [7:0]             loss_cnt_r;
  logic                   lost_sticky_r;
  logic                   timeout_sticky_r;
  logic                   locked_r;
  logic                   irq_r;
  logic                   rd_valid_r;
  logic [31:0]            rd_data_r;
  logic [31:0]            rd_word_s;
  logic                   enter_wait_s;
  logic                   lock_evt_s;
  logic                   loss_evt_s;
  logic                   timeout_hit_s;

  assign lock_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous lock input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= pll_lock_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; dropping the enable overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    if (!pllen_i) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:      next_state_s = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s && (filt_cnt_r == FILT_LAST)) begin
            next_state_s = LOCKED;
          end else begin
            next_state_s = WAIT_LOCK;
          end
        end
        LOCKED: begin
          if (!lock_s) begin
            next_state_s = LOST;
          end else begin
            next_state_s = LOCKED;
          end
        end
        LOST:      next_state_s = WAIT_LOCK;
        default:   next_state_s = IDLE;
      endcase
    end
  end

  assign enter_wait_s  = (next_state_s == WAIT_LOCK) && (state_r != WAIT_LOCK);
  assign lock_evt_s    = (state_r == WAIT_LOCK) && (next_state_s == LOCKED);
  assign loss_evt_s    = (state_r == LOCKED) && (next_state_s == LOST);
  assign timeout_hit_s = (state_r == WAIT_LOCK) && (lt_cnt_r == TIMEOUT);
  assign lt_next_s     = (lt_cnt_r == 16'hFFFF) ? lt_cnt_r : (lt_cnt_r + 16'd1);

  // Lock-time and filter counters, restarted on every entry into WAIT_LOCK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lt_cnt_r   <= 16'd0;
      filt_cnt_r <= 16'd0;
    end else if (enter_wait_s) begin
      lt_cnt_r   <= 16'd0;
      filt_cnt_r <= 16'd0;
    end else if (state_r == WAIT_LOCK) begin
      lt_cnt_r   <= lt_next_s;
      filt_cnt_r <= lock_s ? (filt_cnt_r + 16'd1) : 16'd0;
    end else begin
      lt_cnt_r   <= lt_cnt_r;
      filt_cnt_r <= filt_cnt_r;
    end
  end

  // Status capture: lock time, loss counter, stickies (set beats clear), output flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_time_r      <= 16'd0;
      loss_cnt_r       <= 8'd0;
      lost_sticky_r    <= 1'b0;
      timeout_sticky_r <= 1'b0;
      locked_r         <= 1'b0;
      irq_r            <= 1'b0;
    end else begin
      if (lock_evt_s) begin
        lock_time_r <= lt_next_s;
      end
      if (loss_evt_s && (loss_cnt_r != 8'hFF)) begin
        loss_cnt_r <= loss_cnt_r + 8'd1;
      end
      if (loss_evt_s) begin
        lost_sticky_r <= 1'b1;
      end else if (en_write && wr_clr[0]) begin
        lost_sticky_r <= 1'b0;
      end
      if (timeout_hit_s) begin
        timeout_sticky_r <= 1'b1;
      end else if (en_write && wr_clr[1]) begin
        timeout_sticky_r <= 1'b0;
      end
      locked_r <= (next_state_s == LOCKED);
      irq_r    <= loss_evt_s;
    end
  end

  // Read word mux over current (pre-update) register values.
  always_comb begin
    rd_word_s = 32'd0;
    case (rd_addr)
      2'd0:    rd_word_s = {26'd0, timeout_sticky_r, lost_sticky_r, locked_r, lock_s, state_r};
      2'd1:    rd_word_s = {16'd0, lock_time_r};
      2'd2:    rd_word_s = {24'd0, loss_cnt_r};
      2'd3:    rd_word_s = ID_WORD;
      default: rd_word_s = 32'd0;
    endcase
  end

  // Registered read port; data forced to zero when not valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'd0;
    end else begin
      rd_valid_r <= en_read;
      rd_data_r  <= en_read ? rd_word_s : 32'd0;
    end
  end

  assign rd_data       = rd_data_r;
  assign rd_valid      = rd_valid_r;
  assign locked_o      = locked_r;
  assign lock_lost_irq = irq_r;

endmodule

// File: tb/tb_pll_status_rdbk.sv
// Scoreboard bench for pll_status_rdbk: reads push expected words tagged with their
// due cycle; a negedge monitor retires them and checks the port is quiet otherwise.
module tb_pll_status_rdbk;

  localparam int          SS        = 2;
  localparam int          LF        = 4;
  localparam logic [15:0] TO        = 16'd4000;
  localparam logic [31:0] ID_WORD   = 32'h504C_4C31;
  localparam int          LOCK_DLY  = 100;
  // Entry edge to lock edge: lock delay, then SS sync stages, then LF filter samples.
  localparam int          FIRST_LT  = LOCK_DLY + SS + LF - 1;
  localparam int          RELOCK_LT = SS + LF - 1;

  logic        clk = 1'b0;
  logic        rst_i, pllen_i, pll_lock_i, en_read, en_write;
  logic [1:0]  rd_addr, wr_clr;
  logic [31:0] rd_data;
  logic        rd_valid, locked_o, lock_lost_irq;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   mon_on = 1'b0;
  int   c0;
  int   irq_n;
  int   irq_sum;

  pll_status_rdbk #(.SYNC_STAGES(SS), .LOCK_FILTER(LF), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .pllen_i(pllen_i), .pll_lock_i(pll_lock_i),
    .en_read(en_read), .rd_addr(rd_addr), .en_write(en_write), .wr_clr(wr_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .locked_o(locked_o),
    .lock_lost_irq(lock_lost_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    en_read  = 1'b0;
    en_write = 1'b0;
    wr_clr   = 2'b00;
  endtask

  // Issue a read this cycle; a read under reset is expected to be dropped.
  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    en_read = 1'b1;
    rd_addr = a;
    if (!rst_i) sb_q.push_back('{due: cyc + 1, data: e});
  endtask

  // Drop lock for 3 cycles, then restore it and wait for relock (cycle L = entry).
  task automatic lose_and_relock(input bit clr_at_loss, input bit probe, output int n);
    n = 0;
    pll_lock_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lock_lost_irq) n++;
      if (i == 3) pll_lock_i = 1'b1;
      if (clr_at_loss && i == 2) begin
        en_write = 1'b1;
        wr_clr   = 2'b01;
      end
      if (probe && i == 3) begin
        chk("irq_at_loss", 32'(lock_lost_irq), 32'd1);
        chk("locked_in_lost", 32'(locked_o), 32'd0);
        rd(2'd0, 32'h13);
      end
      if (probe && i == 4) rd(2'd0, 32'h11);
      step();
    end
  endtask

  // Read-port monitor.
  always @(negedge clk) begin
    if (mon_on) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, e.data);
      end else begin
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk("idle_data", rd_data, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; pllen_i = 1'b0; pll_lock_i = 1'b0;
    en_read = 1'b0; rd_addr = 2'd0; en_write = 1'b0; wr_clr = 2'b00;
    repeat (3) step();
    mon_on = 1'b1;
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_irq", 32'(lock_lost_irq), 32'd0);
    rst_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), (a == 3) ? ID_WORD : 32'd0);
      step();
    end

    // Timeout with lock stuck low: sticky appears the cycle after the counter hits TO.
    pllen_i = 1'b1;
    c0 = cyc;
    step();
    while (cyc < c0 + int'(TO) + 1) step();
    rd(2'd0, 32'h01); step();
    rd(2'd0, 32'h21); step();
    repeat (50) step();
    rd(2'd0, 32'h21); step();
    en_write = 1'b1; wr_clr = 2'b10; step();
    rd(2'd0, 32'h01); step();

    pllen_i = 1'b0; step(); step();
    rd(2'd0, 32'h00); step();

    // Lock acquisition with a short glitch that must not lock.
    pllen_i = 1'b1;
    c0 = cyc;
    step();
    while (cyc < c0 + LOCK_DLY) begin
      if (cyc == c0 + 20) pll_lock_i = 1'b1;
      if (cyc == c0 + 23) pll_lock_i = 1'b0;
      chk("glitch_locked", 32'(locked_o), 32'd0);
      step();
    end
    pll_lock_i = 1'b1;
    while (cyc < c0 + FIRST_LT) step();
    chk("locked_early", 32'(locked_o), 32'd0);
    step();
    chk("locked_set", 32'(locked_o), 32'd1);
    rd(2'd1, 32'(FIRST_LT)); step();
    rd(2'd0, 32'h0E); step();

    // First loss event.
    lose_and_relock(1'b0, 1'b1, irq_n);
    chk("irq_count1", 32'(irq_n), 32'd1);
    chk("relocked1", 32'(locked_o), 32'd1);
    rd(2'd2, 32'd1); step();
    rd(2'd0, 32'h1E); step();
    rd(2'd1, 32'(RELOCK_LT)); step();

    // Clear then a loss coinciding with another clear: set wins.
    en_write = 1'b1; wr_clr = 2'b01; step();
    rd(2'd0, 32'h0E); step();
    lose_and_relock(1'b1, 1'b1, irq_n);
    chk("irq_count2", 32'(irq_n), 32'd1);
    rd(2'd0, 32'h1E); step();
    en_write = 1'b1; wr_clr = 2'b01; step();
    rd(2'd0, 32'h0E); step();
    rd(2'd2, 32'd2); step();

    // Drive the loss counter well past saturation.
    irq_sum = 0;
    for (int k = 0; k < 298; k++) begin
      lose_and_relock(1'b0, 1'b0, irq_n);
      irq_sum += irq_n;
    end
    chk("irq_total", 32'(irq_sum), 32'd298);
    rd(2'd2, 32'hFF); step();

    // Back-to-back reads, then reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0:       rd(2'd0, 32'h1E);
        1:       rd(2'd1, 32'(RELOCK_LT));
        2:       rd(2'd2, 32'hFF);
        default: rd(2'd3, ID_WORD);
      endcase
      step();
    end
    rst_i = 1'b1; pllen_i = 1'b0; pll_lock_i = 1'b0;
    rd(2'd3, ID_WORD);
    step();
    chk("rst_mid_locked", 32'(locked_o), 32'd0);
    chk("rst_mid_irq", 32'(lock_lost_irq), 32'd0);
    step();
    rst_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), (a == 3) ? ID_WORD : 32'd0);
      step();
    end
    repeat (3) step();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
